// File: rtl/ssgd_pkg.sv
// Shared constants for the sequence generator/detector run controller:
// FSM state encoding and default widths.
package ssgd_pkg;

    localparam int DEF_LEN_W = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ssgd_run_ctrl_if.sv
// Control/status bundle between the run controller and its user.
// Optional first-hit capture ports appear when SSGD_FIRST_HIT_EN is defined.
interface ssgd_run_ctrl_if import ssgd_pkg::*; #(
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [LEN_W-1:0] run_len;
    logic             seq_jug;
    logic             gen_load;
    logic             step_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
    logic [LEN_W-1:0] bit_idx;
`ifdef SSGD_FIRST_HIT_EN
    logic [LEN_W-1:0] first_hit;
    logic             first_hit_vld;
`endif

    modport master (
`ifdef SSGD_FIRST_HIT_EN
        input  first_hit, first_hit_vld,
`endif
        output start, run_len, seq_jug,
        input  gen_load, step_en, busy, done, hit_cnt, bit_idx
    );

    modport slave (
`ifdef SSGD_FIRST_HIT_EN
        output first_hit, first_hit_vld,
`endif
        input  start, run_len, seq_jug,
        output gen_load, step_en, busy, done, hit_cnt, bit_idx
    );

endinterface

// File: rtl/ssgd_sat_cnt.sv
// Saturating up-counter: synchronous clear has priority, sticks at all-ones.
module ssgd_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ssgd_run_ctrl.sv
// Test-run controller: load generator, shift run_len cycles, drain one
// detector-latency cycle, pulse done. Define SSGD_FIRST_HIT_EN for first-hit capture.
module ssgd_run_ctrl import ssgd_pkg::*; #(
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic           clk,
    input logic           rst,
    ssgd_run_ctrl_if.slave bus
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic             accept;
    logic             hit;

    logic gen_load_q, step_en_q, busy_q, done_q;
    logic gen_load_nxt, step_en_nxt, busy_nxt, done_nxt;

    assign accept = (state == ST_IDLE) && bus.start;
    // The DRAIN cycle still counts: it carries the detector's delayed verdict on the last bit.
    assign hit    = bus.seq_jug && ((state == ST_RUN) || (state == ST_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (len_q != '0) ? ST_RUN : ST_DRAIN;
            ST_RUN:   if (bit_idx_q == len_q - LEN_W'(1)) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Outputs are decoded from the next state and registered, so they line up with state.
        gen_load_nxt = (state_nxt == ST_LOAD);
        step_en_nxt  = (state_nxt == ST_RUN);
        busy_nxt     = (state_nxt != ST_IDLE);
        done_nxt     = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_load_q <= 1'b0;
            step_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            gen_load_q <= gen_load_nxt;
            step_en_q  <= step_en_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            bit_idx_q <= '0;
        end else if (accept) begin
            len_q     <= bus.run_len;
            bit_idx_q <= '0;
        end else if (state == ST_RUN) begin
            bit_idx_q <= bit_idx_q + LEN_W'(1);
        end
    end

    ssgd_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (hit),
        .cnt (hit_cnt_q)
    );

`ifdef SSGD_FIRST_HIT_EN
    logic [LEN_W-1:0] first_hit_q;
    logic             first_hit_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_hit_q     <= '0;
            first_hit_vld_q <= 1'b0;
        end else if (accept) begin
            first_hit_q     <= '0;
            first_hit_vld_q <= 1'b0;
        end else if (hit && !first_hit_vld_q) begin
            first_hit_q     <= bit_idx_q;
            first_hit_vld_q <= 1'b1;
        end
    end

    assign bus.first_hit     = first_hit_q;
    assign bus.first_hit_vld = first_hit_vld_q;
`endif

    assign bus.gen_load = gen_load_q;
    assign bus.step_en  = step_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.bit_idx  = bit_idx_q;

endmodule

// File: doc/ssgd_run_ctrl.md
SSGD_RUN_CTRL -- requirements
Module: ssgd_run_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of run_len and bit_idx.
REQ-002 SHALL have parameter CNT_W, default 8: width of hit_cnt.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge; no other clocks.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a test run; sampled only in IDLE.
REQ-006 SHALL have port run_len, input, LEN_W: number of generator shift cycles; sampled when start is accepted.
REQ-007 SHALL have port seq_jug, input, 1: detector hit flag, 1 = pattern 10110 seen this cycle.
REQ-008 SHALL have port gen_load, output, 1: one-cycle load pulse to the sequence generator.
REQ-009 SHALL have port step_en, output, 1: generator/detector shift enable.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at run end.
REQ-012 SHALL have port hit_cnt, output, CNT_W: hits counted in the last or current run.
REQ-013 SHALL have port bit_idx, output, LEN_W: shift cycles completed in the current run.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-015 IDLE to LOAD SHALL occur when start=1; run_len SHALL be latched into an internal length register in the same cycle.
REQ-016 LOAD SHALL last exactly 1 cycle: gen_load=1, step_en=0, hit_cnt and bit_idx cleared to 0.
REQ-017 LOAD SHALL go to RUN when the latched length is non-zero, else directly to DRAIN.
REQ-018 RUN SHALL hold step_en=1 and increment bit_idx by 1 per cycle.
REQ-019 RUN SHALL go to DRAIN in the cycle bit_idx reaches the latched length, so step_en is high for exactly run_len cycles.
REQ-020 DRAIN SHALL last 1 cycle with step_en=0, to absorb the detector's 1-cycle output latency.
REQ-021 DRAIN SHALL go to DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 hit_cnt SHALL increment when seq_jug=1 in RUN or DRAIN, and only there.
REQ-024 hit_cnt SHALL saturate at all-ones with no wrap.
REQ-025 seq_jug SHALL be ignored in IDLE, LOAD and DONE.
REQ-026 start SHALL be ignored while busy=1; no queuing.
REQ-027 hit_cnt and bit_idx SHALL hold their final values in IDLE until the next LOAD.
REQ-028 A start asserted in the same cycle as done SHALL be ignored; start accepted again from the next IDLE cycle.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 rst=1 SHALL force state to IDLE at any time, including mid-run.
REQ-031 rst=1 SHALL set gen_load, step_en, busy, done, hit_cnt, bit_idx and the length register to 0.
REQ-032 The first accepted start after rst deasserts SHALL behave identically to a start after power-up.

Configuration
REQ-033 When macro SSGD_FIRST_HIT_EN is defined, the block SHALL add output first_hit, LEN_W, and output first_hit_vld, 1.
REQ-034 first_hit SHALL capture bit_idx at the first counted hit of a run; first_hit_vld SHALL be set at that capture.
REQ-035 first_hit and first_hit_vld SHALL clear in LOAD and on reset.
REQ-036 When SSGD_FIRST_HIT_EN is undefined, these ports and registers SHALL be absent, with all other behaviour unchanged.

Structure
REQ-037 Shared package ssgd_pkg SHALL hold the FSM state encoding constants (3-bit: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4) and the default LEN_W and CNT_W values.
REQ-038 One sub-module ssgd_sat_cnt SHALL implement the saturating hit counter, parameterised by width, with clear and increment inputs; all other logic SHALL be in ssgd_run_ctrl.

Verification
REQ-039 Bench SHALL cover: start=1 with run_len=16 and seq_jug held 0 -> gen_load 1 cycle, step_en high exactly 16 cycles, done 19 cycles after start accepted, hit_cnt=0.
REQ-040 Bench SHALL cover: run_len=16, seq_jug pulsed at RUN cycles 5 and 11 plus the DRAIN cycle -> hit_cnt=3; with the macro on, first_hit=5.
REQ-041 Bench SHALL cover: run_len=0 -> LOAD, DRAIN, DONE in 3 cycles, step_en never high, hit_cnt=0.
REQ-042 Bench SHALL cover: CNT_W=2, run_len=10, seq_jug held 1 -> hit_cnt saturates at 3.
REQ-043 Bench SHALL cover: start pulsed during RUN and in the done cycle -> no restart, run length unchanged.
REQ-044 Bench SHALL cover: rst asserted at RUN cycle 7 -> all outputs 0 asynchronously; a new start with run_len=4 then completes normally.
